// File: rtl/sd_card_init.sv
// sd_card_init: SD-card SPI-mode power-up sequencer.
//   Dummy clocks with CS high, then CMD0, optional CMD8, then the CMD55/ACMD41
//   loop until the card leaves idle. Commands go out through sd_card_cmd.
// Optional feature macro: SD_INIT_CMD8_EN. When it is defined, CMD8 is sent after
//   CMD0, SDv2 cards are detected, and HCS is requested in ACMD41.
module sd_card_init #(
  parameter int DUMMY_CLKS     = 80,
  parameter int CMD0_RETRIES   = 10,
  parameter int ACMD41_RETRIES = 1000,
  parameter int RESP_TIMEOUT   = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_init,
  output logic        o_cs_n,
  output logic        o_send_cmd,
  output logic [2:0]  o_cmd_select,
  output logic [31:0] o_cmd_arg,
  input  logic        i_confirm_pin,
  input  logic [7:0]  i_response_status,
  output logic        o_init_done,
  output logic        o_init_error,
  output logic [2:0]  o_error_code,
  output logic        o_sd_v2
);

  localparam logic [2:0] SEL_CMD0   = 3'd0;
  localparam logic [2:0] SEL_CMD55  = 3'd2;
  localparam logic [2:0] SEL_ACMD41 = 3'd3;
  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_CMD0   = 3'd1;
  localparam logic [2:0] ERR_ACMD41 = 3'd3;
  localparam logic [2:0] ERR_TMO    = 3'd4;
`ifdef SD_INIT_CMD8_EN
  localparam logic [2:0] SEL_CMD8   = 3'd1;
  localparam logic [2:0] ERR_CMD8   = 3'd2;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_POWERUP,
    S_CMD0,
    S_CMD0_W,
`ifdef SD_INIT_CMD8_EN
    S_CMD8,
    S_CMD8_W,
`endif
    S_CMD55,
    S_CMD55_W,
    S_ACMD41,
    S_ACMD41_W,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q;
  logic        cs_n_q, send_q, done_q, err_q;
  logic [2:0]  sel_q, code_q;
  logic [31:0] arg_q;
  // cnt_q counts dummy clocks in POWERUP and response wait cycles in the _W states
  logic [31:0] cnt_q;
  logic [31:0] cmd0_cnt_q, a41_cnt_q;
  logic [31:0] acmd41_arg;
  logic        tmo_hit;

`ifdef SD_INIT_CMD8_EN
  logic sd_v2_q;
  // HCS is only requested from cards that answered CMD8
  assign acmd41_arg = sd_v2_q ? 32'h4000_0000 : 32'h0;
  assign o_sd_v2    = sd_v2_q;
`else
  assign acmd41_arg = 32'h0;
  assign o_sd_v2    = 1'b0;
`endif

  assign tmo_hit = (cnt_q == 32'(RESP_TIMEOUT - 1));

  // Sequencer: state, counters and all outputs are registered here
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cs_n_q     <= 1'b1;
      send_q     <= 1'b0;
      sel_q      <= SEL_CMD0;
      arg_q      <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      cnt_q      <= 32'h0;
      cmd0_cnt_q <= 32'h0;
      a41_cnt_q  <= 32'h0;
`ifdef SD_INIT_CMD8_EN
      sd_v2_q    <= 1'b0;
`endif
    end else begin
      send_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start_init) begin
            state_q    <= S_POWERUP;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
            cnt_q      <= 32'h0;
            cmd0_cnt_q <= 32'h0;
            a41_cnt_q  <= 32'h0;
`ifdef SD_INIT_CMD8_EN
            sd_v2_q    <= 1'b0;
`endif
          end
        end
        S_POWERUP: begin
          if (cnt_q == 32'(DUMMY_CLKS - 1)) begin
            cs_n_q  <= 1'b0;
            state_q <= S_CMD0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_CMD0: begin
          send_q  <= 1'b1;
          sel_q   <= SEL_CMD0;
          arg_q   <= 32'h0;
          cnt_q   <= 32'h0;
          state_q <= S_CMD0_W;
        end
`ifdef SD_INIT_CMD8_EN
        S_CMD8: begin
          send_q  <= 1'b1;
          sel_q   <= SEL_CMD8;
          arg_q   <= 32'h0000_01AA;
          cnt_q   <= 32'h0;
          state_q <= S_CMD8_W;
        end
`endif
        S_CMD55: begin
          send_q  <= 1'b1;
          sel_q   <= SEL_CMD55;
          arg_q   <= 32'h0;
          cnt_q   <= 32'h0;
          state_q <= S_CMD55_W;
        end
        S_ACMD41: begin
          send_q  <= 1'b1;
          sel_q   <= SEL_ACMD41;
          arg_q   <= acmd41_arg;
          cnt_q   <= 32'h0;
          state_q <= S_ACMD41_W;
        end
`ifdef SD_INIT_CMD8_EN
        S_CMD0_W, S_CMD8_W, S_CMD55_W, S_ACMD41_W: begin
`else
        S_CMD0_W, S_CMD55_W, S_ACMD41_W: begin
`endif
          // a confirm in the timeout cycle still counts as an answer
          if (i_confirm_pin) begin
            case (state_q)
              S_CMD0_W: begin
                if (i_response_status == 8'h01) begin
`ifdef SD_INIT_CMD8_EN
                  state_q <= S_CMD8;
`else
                  state_q <= S_CMD55;
`endif
                end else if (cmd0_cnt_q == 32'(CMD0_RETRIES - 1)) begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  code_q  <= ERR_CMD0;
                  cs_n_q  <= 1'b1;
                end else begin
                  cmd0_cnt_q <= cmd0_cnt_q + 32'd1;
                  state_q    <= S_CMD0;
                end
              end
`ifdef SD_INIT_CMD8_EN
              S_CMD8_W: begin
                if (i_response_status == 8'h01) begin
                  sd_v2_q <= 1'b1;
                  state_q <= S_CMD55;
                end else if (i_response_status == 8'h05) begin
                  // illegal command: SDv1 or MMC, continue without HCS
                  sd_v2_q <= 1'b0;
                  state_q <= S_CMD55;
                end else begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  code_q  <= ERR_CMD8;
                  cs_n_q  <= 1'b1;
                end
              end
`endif
              S_CMD55_W: begin
                if (i_response_status == 8'h00 || i_response_status == 8'h01) begin
                  state_q <= S_ACMD41;
                end else begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  code_q  <= ERR_ACMD41;
                  cs_n_q  <= 1'b1;
                end
              end
              S_ACMD41_W: begin
                if (i_response_status == 8'h00) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else if (i_response_status == 8'h01 &&
                             a41_cnt_q != 32'(ACMD41_RETRIES - 1)) begin
                  a41_cnt_q <= a41_cnt_q + 32'd1;
                  state_q   <= S_CMD55;
                end else begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  code_q  <= ERR_ACMD41;
                  cs_n_q  <= 1'b1;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end else if (tmo_hit) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            code_q  <= ERR_TMO;
            cs_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_cs_n       = cs_n_q;
  assign o_send_cmd   = send_q;
  assign o_cmd_select = sel_q;
  assign o_cmd_arg    = arg_q;
  assign o_init_done  = done_q;
  assign o_init_error = err_q;
  assign o_error_code = code_q;

endmodule
